// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and
// default geometry of the attached RAM.
package lsu_pkg;
    localparam int LSU_ADDR_W = 10;
    localparam int LSU_DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RSP  = 3'd4,
        ERR  = 3'd5
    } state_e;

    // Rejects the reserved size and any access not aligned to its own width.
    function automatic logic is_illegal(input size_e size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: is_illegal = 1'b0;
            SZ_HALF: is_illegal = lane[0];
            SZ_WORD: is_illegal = (lane != 2'b00);
            default: is_illegal = 1'b1;
        endcase
    endfunction
endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extracts and extends load data from a RAM word and
// merges sub-word store data into a RAM word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] q,
    input  logic [1:0]  lane,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = q[{lane, 3'b000} +: 8];
        half_v = lane[1] ? q[31:16] : q[15:0];

        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
            SZ_HALF: load_data = {{16{~is_unsigned & half_v[15]}}, half_v};
            default: load_data = q;
        endcase

        merged = q;
        case (size)
            SZ_BYTE: merged[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (lane[1]) merged[31:16] = wdata;
                else         merged[15:0]  = wdata;
            end
            default: merged = q;
        endcase
    end
endmodule

// File: rtl/lsu_ram.sv
// Load/store unit bridging a single-request core port to a synchronous RAM
// with one-cycle read latency; sub-word stores use read-modify-write.
//   state | meaning
//   IDLE  | ready for a request
//   RD    | RAM address presented, read in flight
//   CAP   | ram_q valid; capture load data or merge store data
//   WR    | ram_wren high for exactly this cycle
//   RSP   | rsp_valid high, normal completion
//   ERR   | rsp_valid and rsp_err high, no RAM access made
module lsu_ram
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);
    state_e      state;
    logic        we_r;
    logic        uns_r;
    size_e       size_r;
    logic [1:0]  lane_r;
    logic [15:0] wdata_r;
    logic [31:0] load_data;
    logic [31:0] merged;
    size_e       req_size_e;

    assign req_size_e = size_e'(req_size);
    assign req_ready  = (state == IDLE);

    lsu_align u_align (
        .q           (ram_q),
        .lane        (lane_r),
        .size        (size_r),
        .is_unsigned (uns_r),
        .wdata       (wdata_r),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            ram_wren    <= 1'b0;
            ram_data    <= '0;
            ram_address <= '0;
            we_r        <= 1'b0;
            uns_r       <= 1'b0;
            size_r      <= SZ_BYTE;
            lane_r      <= 2'b00;
            wdata_r     <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            ram_wren  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        ram_address <= req_addr[ADDR_W+1:2];
                        we_r        <= req_we;
                        uns_r       <= req_unsigned;
                        size_r      <= req_size_e;
                        lane_r      <= req_addr[1:0];
                        wdata_r     <= req_wdata[15:0];
                        rsp_rdata   <= '0;
                        if (is_illegal(req_size_e, req_addr[1:0])) begin
                            state     <= ERR;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (req_we && req_size_e == SZ_WORD) begin
                            // full-word stores need no read of the old word
                            state    <= WR;
                            ram_wren <= 1'b1;
                            ram_data <= req_wdata;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD:  state <= CAP;
                CAP: begin
                    if (we_r) begin
                        ram_data <= merged;
                        ram_wren <= 1'b1;
                        state    <= WR;
                    end else begin
                        rsp_rdata <= load_data;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                WR: begin
                    rsp_valid <= 1'b1;
                    state     <= RSP;
                end
                RSP:     state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ram.sv
// Self-checking bench for lsu_ram: directed vectors, reset corner cases,
// back-to-back loads and randomized traffic against a behavioural model.
module tb_lsu_ram;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  ram_address;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q;

    int tests  = 0;
    int failed = 0;

    logic [31:0] ram     [1024];
    logic [31:0] ref_mem [1024];
    logic        mem_clear;

    always #5 clock = ~clock;

    lsu_ram dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q)
    );

    // RAM: latches the address at an edge, data valid the following cycle
    always @(posedge clock) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
        end else if (ram_wren) begin
            ram[ram_address] <= ram_data;
        end
        ram_q <= ram[ram_address];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Behavioural model: result of a request and its effect on memory.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [11:0] addr, input logic [31:0] wd,
                         output logic [31:0] exp_rdata, output logic exp_err,
                         output int exp_lat);
        int unsigned w, v, shift, mask;
        int idx;
        idx   = int'(addr) / 4;
        shift = 8 * (int'(addr) % 4);
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        if (sz == 2'd3 || (sz == 2'd1 && (addr % 2) != 0) || (sz == 2'd2 && (addr % 4) != 0)) begin
            exp_err = 1'b1;
            exp_lat = 1;
            return;
        end
        w    = ref_mem[idx];
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        if (we) begin
            ref_mem[idx] = (w & ~(mask << shift)) | ((wd & mask) << shift);
            exp_lat = (sz == 2'd2) ? 2 : 4;
        end else begin
            v = (w >> shift) & mask;
            if (!uns && sz == 2'd0 && v >= 128)   v = v + 32'hFFFF_FF00;
            if (!uns && sz == 2'd1 && v >= 32768) v = v + 32'hFFFF_0000;
            exp_rdata = v;
            exp_lat   = 3;
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [11:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int wrens, output logic [9:0] wr_addr, output logic [31:0] wr_data);
        int guard;
        bit got;
        @(negedge clock);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = -1; wrens = 0; got = 0; rdata = 32'hx; err = 1'bx;
        wr_addr = 10'h0; wr_data = 32'h0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clock);
            if (ram_wren) begin
                wrens++;
                wr_addr = ram_address;
                wr_data = ram_data;
            end
            if (rsp_valid) begin
                got = 1; lat = c; rdata = rsp_rdata; err = rsp_err;
            end
        end
        @(negedge clock);
        chk("rsp_single_cycle", {31'b0, rsp_valid}, 32'h0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [11:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        int          lat, exp_lat, wr;
        logic [9:0]  wa;
        logic [31:0] wdv;
        logic [31:0] q3 [$];
        logic [31:0] b2b_exp [3];
        int          bad;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 12'h004, 32'd43,        32'd43 * 0,     1'b0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 12'h004, 32'h0,         32'd43,         1'b0};
        vecs[2]  = '{1'b1, 2'd2, 1'b0, 12'h080, 32'd61,        32'h0,          1'b0};
        vecs[3]  = '{1'b1, 2'd0, 1'b0, 12'h081, 32'h0000_00AB, 32'h0,          1'b0};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 12'h081, 32'h0,         32'hFFFF_FFAB,  1'b0};
        vecs[5]  = '{1'b0, 2'd0, 1'b1, 12'h081, 32'h0,         32'h0000_00AB,  1'b0};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 12'h080, 32'h0,         32'hFFFF_AB3D,  1'b0};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 12'h080, 32'h0,         32'h0000_AB3D,  1'b0};
        vecs[8]  = '{1'b0, 2'd1, 1'b0, 12'h003, 32'h0,         32'h0,          1'b1};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 12'h006, 32'hDEAD_BEEF, 32'h0,          1'b1};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 12'h004, 32'h0,         32'd43,         1'b0};

        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        reset = 1'b1; mem_clear = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        mem_clear = 1'b0;
        reset = 1'b0;
        chk("reset_req_ready", {31'b0, req_ready}, 32'h1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_ram_wren", {31'b0, ram_wren}, 32'h0);
        chk("reset_ram_data", ram_data, 32'h0);
        chk("reset_ram_address", {22'b0, ram_address}, 32'h0);

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            model(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, exp_rd, exp_er, exp_lat);
            do_req(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, rd, er, lat, wr, wa, wdv);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d_latency", i), lat, exp_lat);
            chk($sformatf("vec%0d_wren_pulses", i), wr, (vecs[i].we && !vecs[i].exp_err) ? 1 : 0);
            if (i == 0) begin
                chk("word_store_ram_address", {22'b0, wa}, 32'd1);
                chk("word_store_ram_data", wdv, 32'd43);
            end
            if (i == 3) begin
                chk("byte_store_ram_address", {22'b0, wa}, 32'd32);
                chk("byte_store_merged", wdv, 32'h0000_AB3D);
            end
        end
        chk("ram_word32", ram[32], 32'h0000_AB3D);
        chk("ram_word1_after_errors", ram[1], 32'd43);

        // Reset in RD of a byte store: the store is abandoned
        @(negedge clock);
        req_we = 1; req_size = 2'd0; req_unsigned = 0; req_addr = 12'h0F1; req_wdata = 32'h5A;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rd_reset_req_ready", {31'b0, req_ready}, 32'h1);
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (ram_wren || rsp_valid) bad++;
            @(negedge clock);
        end
        chk("rd_reset_no_activity", bad, 0);
        chk("rd_reset_ram_unchanged", ram[60], ref_mem[60]);

        // Reset on the WR edge: the write lands, no response follows
        @(negedge clock);
        req_we = 1; req_size = 2'd2; req_addr = 12'h0C8; req_wdata = 32'hCAFE_0001;
        req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        chk("wr_reset_wren_seen", {31'b0, ram_wren}, 32'h1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        ref_mem[50] = 32'hCAFE_0001;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (ram_wren || rsp_valid) bad++;
            @(negedge clock);
        end
        chk("wr_reset_no_activity", bad, 0);
        chk("wr_reset_write_done", ram[50], 32'hCAFE_0001);

        // Back-to-back word loads with req_valid held high
        b2b_exp[0] = 32'h1111_1111; b2b_exp[1] = 32'h2222_2222; b2b_exp[2] = 32'h3333_3333;
        for (int k = 0; k < 3; k++) begin
            model(1'b1, 2'd2, 1'b0, 12'(160 + 4 * k), b2b_exp[k], exp_rd, exp_er, exp_lat);
            do_req(1'b1, 2'd2, 1'b0, 12'(160 + 4 * k), b2b_exp[k], rd, er, lat, wr, wa, wdv);
        end
        begin
            int  n_acc;
            bit  prev_rv, rv, rdy, acc;
            @(negedge clock);
            req_we = 0; req_size = 2'd2; req_unsigned = 0; req_addr = 12'd160;
            req_valid = 1'b1;
            n_acc = 0; prev_rv = 0;
            for (int cyc = 0; cyc < 40 && q3.size() < 3; cyc++) begin
                rv  = rsp_valid;
                rdy = req_ready;
                acc = rdy && req_valid;
                if (prev_rv && q3.size() < 3)
                    chk("b2b_ready_after_rsp", {31'b0, acc}, 32'h1);
                if (rv) q3.push_back(rsp_rdata);
                prev_rv = rv;
                @(posedge clock);
                #1;
                if (acc) begin
                    n_acc++;
                    if (n_acc < 3) req_addr = 12'(160 + 4 * n_acc);
                    else req_valid = 1'b0;
                end
                @(negedge clock);
            end
            req_valid = 1'b0;
            chk("b2b_pulse_count", q3.size(), 3);
            chk("b2b_accepts", n_acc, 3);
            for (int k = 0; k < 3; k++)
                chk($sformatf("b2b_data%0d", k), (k < q3.size()) ? q3[k] : 32'hx, b2b_exp[k]);
        end
        repeat (3) @(negedge clock);

        // Randomized traffic against the model
        for (int n = 0; n < 200; n++) begin
            logic        we, uns;
            logic [1:0]  sz;
            logic [11:0] addr;
            logic [31:0] wd;
            we   = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            addr = 12'($urandom_range(0, 63));
            wd   = $urandom;
            model(we, sz, uns, addr, wd, exp_rd, exp_er, exp_lat);
            do_req(we, sz, uns, addr, wd, rd, er, lat, wr, wa, wdv);
            chk($sformatf("rnd%0d_rdata", n), rd, exp_rd);
            chk($sformatf("rnd%0d_err", n), {31'b0, er}, {31'b0, exp_er});
            chk($sformatf("rnd%0d_latency", n), lat, exp_lat);
            chk($sformatf("rnd%0d_wren_pulses", n), wr, (we && !exp_er) ? 1 : 0);
            if (wr == 1)
                chk($sformatf("rnd%0d_wr_addr", n), {22'b0, wa}, {22'b0, addr[11:2]});
        end

        bad = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk("final_ram_contents_mismatched_words", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
